// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
// Module   : weight_loader
// Brief    : Streams DEPTH weight bytes from a valid/ready byte interface into
//            neuron_layer as set_weight/set_addr/swr write strobes, then holds
//            swr low for a settle window and pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module weight_loader #(
  parameter int DEPTH     = 32,
  parameter int ADDR_SIZE = 5,
  parameter int SETTLE    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic [7:0]           set_weight,
  output logic [ADDR_SIZE-1:0] set_addr,
  output logic                 swr,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  localparam logic [ADDR_SIZE-1:0] C_LAST_IDX    = ADDR_SIZE'(DEPTH - 1);
  localparam logic [3:0]           C_SETTLE_INIT = 4'(SETTLE - 1);

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] idx_q, idx_d;
  logic [3:0]           scnt_q, scnt_d;
  logic [7:0]           weight_q, weight_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic                 swr_q, swr_d;
  logic                 done_q, done_d;

  // Handshake and status decode from state only (abort blocks acceptance).
  always_comb begin
    byte_ready = (state_q == S_LOAD) && !abort;
    busy       = (state_q != S_IDLE);
  end

  // Next-state logic: byte acceptance, write-strobe generation, settle count.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    scnt_d   = scnt_q;
    weight_d = weight_q;
    addr_d   = addr_q;
    swr_d    = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          // Abort beats any byte presented in the same cycle, including the last.
          state_d = S_IDLE;
        end else if (byte_valid) begin
          weight_d = byte_in;
          addr_d   = idx_q;
          swr_d    = 1'b1;
          if (idx_q == C_LAST_IDX) begin
            // idx is left at the last address so it never wraps within a load.
            state_d = S_SETTLE;
            scnt_d  = C_SETTLE_INIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (scnt_q == 4'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          scnt_d = scnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      scnt_q   <= 4'd0;
      weight_q <= 8'd0;
      addr_q   <= '0;
      swr_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      scnt_q   <= scnt_d;
      weight_q <= weight_d;
      addr_q   <= addr_d;
      swr_q    <= swr_d;
      done_q   <= done_d;
    end
  end

  assign set_weight = weight_q;
  assign set_addr   = addr_q;
  assign swr        = swr_q;
  assign done       = done_q;

endmodule
`default_nettype wire
